// File: rtl/serial_pkg.sv
// Shared types for the serial receiver: parity modes, receive FSM states and
// the FIFO entry layout.
package serial_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Data is sized for the widest frame; narrower frames are zero-extended.
  typedef struct packed {
    logic                     brk;
    logic                     perr;
    logic                     ferr;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout_o
// whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk64,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk64) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk64) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/serial_rx_fifo.sv
// UART receiver with majority-vote sampling, configurable frame format and a
// status-tagged receive FIFO drained by valid/ready.
//
// state     | meaning
// WAIT_IDLE | after reset or break, wait for the line to return high
// IDLE      | line high, watching for a start edge
// START     | validating the start bit at mid-bit
// DATA      | shifting in data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bits; frame completes at the last one
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_DIV    = 278,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk64,
  input  logic                        reset,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_ferr,
  output logic                        rx_perr,
  output logic                        rx_brk,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int CW  = $clog2(CLK_DIV);
  localparam int MID = CLK_DIV / 2;

  logic                 sync1_q;
  logic                 rx_s_q;
  rx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 s0_q;
  logic                 s1_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 any_one_q;
  logic                 push_q;
  rx_entry_t            entry_q;
  logic                 overrun_q;

  logic      maj;
  logic      at_smp;
  logic      last_cnt;
  logic      ferr_n;
  logic      any_n;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  rx_entry_t head;
  logic      unused_head_hi;

  // Third vote is the live sample at Mid+1, so the decision lands on that cycle.
  assign maj      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign at_smp   = (cnt_q == CW'(MID + 1));
  assign last_cnt = (cnt_q == CW'(CLK_DIV - 1));
  assign ferr_n   = ferr_q | ~maj;
  assign any_n    = any_one_q | maj;
  assign pop      = rx_ready & ~fifo_empty;

  always_ff @(posedge clk64) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= WAIT_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      any_one_q  <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      push_q  <= 1'b0;

      if (state_q == IDLE || state_q == WAIT_IDLE || last_cnt) cnt_q <= '0;
      else                                                    cnt_q <= cnt_q + 1'b1;

      if (cnt_q == CW'(MID - 1)) s0_q <= rx_s_q;
      if (cnt_q == CW'(MID))     s1_q <= rx_s_q;

      if (push_q && fifo_full && !pop) overrun_q <= 1'b1;
      else if (clr_overrun)            overrun_q <= 1'b0;

      case (state_q)
        WAIT_IDLE: if (rx_s_q) state_q <= IDLE;
        IDLE: begin
          if (!rx_s_q) begin
            state_q    <= START;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            any_one_q  <= 1'b0;
          end
        end
        START: if (at_smp) state_q <= maj ? IDLE : DATA;
        DATA: begin
          if (at_smp) begin
            shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
            par_q     <= par_q ^ maj;
            any_one_q <= any_n;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 4'(DATA_BITS - 1))
              state_q <= (PARITY == PAR_NONE) ? STOP : serial_pkg::PARITY;
          end
        end
        serial_pkg::PARITY: begin
          if (at_smp) begin
            any_one_q <= any_n;
            perr_q    <= (PARITY == PAR_ODD) ? ~(par_q ^ maj) : (par_q ^ maj);
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (at_smp) begin
            ferr_q     <= ferr_n;
            any_one_q  <= any_n;
            stop_idx_q <= 1'b1;
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              push_q  <= 1'b1;
              entry_q <= '{brk: ~any_n, perr: perr_q, ferr: ferr_n,
                           data: MAX_DATA_BITS'(shreg_q)};
              // A break leaves the line low; wait for it to rise before rearming.
              state_q <= any_n ? IDLE : WAIT_IDLE;
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk64  (clk64),
    .reset  (reset),
    .push_i (push_q),
    .din_i  (entry_q),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_empty ? '0 : head.data[DATA_BITS-1:0];
  assign rx_ferr  = ~fifo_empty & head.ferr;
  assign rx_perr  = ~fifo_empty & head.perr;
  assign rx_brk   = ~fifo_empty & head.brk;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);

  // Zero-extension bits above DATA_BITS carry no information.
  assign unused_head_hi = ^(head.data >> DATA_BITS);

endmodule
